// File: rtl/dmac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmac_pkg
// Description : Shared definitions for the DMAC slave register block:
//               register addresses, FSM state encoding, queue geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package dmac_pkg;

  localparam int FIFO_DEPTH = 4;   // descriptor queue depth (only 4 supported)
  localparam int DESC_W     = 24;  // {SRC, DEST, SIZE}
  localparam int PTR_W      = 2;   // queue pointer width, wraps modulo 4
  localparam int CNT_W      = 3;   // queue occupancy 0..4

  localparam logic [2:0] ADDR_INTR_EN = 3'd0;
  localparam logic [2:0] ADDR_INTR    = 3'd1;
  localparam logic [2:0] ADDR_SRC     = 3'd2;
  localparam logic [2:0] ADDR_DEST    = 3'd3;
  localparam logic [2:0] ADDR_SIZE    = 3'd4;
  localparam logic [2:0] ADDR_PUSH    = 3'd5;
  localparam logic [2:0] ADDR_STATUS  = 3'd6;
  localparam logic [2:0] ADDR_START   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmac_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dmac_desc_fifo
// Description : Synchronous descriptor FIFO (4 x 24). Head word is presented
//               on dout, forced to zero while empty.
// Ports       : clk, reset (sync, active-high)
//               push, din     - write side, ignored when full
//               pop           - advance head, ignored when empty
//               dout          - head descriptor
//               count, full, empty - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_desc_fifo
  import dmac_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DESC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;  // natural wrap modulo 4
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmac_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : dmac_slave_regs
// Description : DMAC slave-side register file, write decode, descriptor
//               queue and issue FSM (IDLE -> ISSUE -> WAIT).
// Ports       : clk, reset (sync, active-high)
//               S_sel, S_wr, S_addr, S_din - bus slave write port
//               reg0_out..reg7_out          - register images for read mux
//               desc_valid/desc_ready/desc_data - descriptor offer to master
//               op_done                     - completion pulse from master
//               irq                         - INTR & INTR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module dmac_slave_regs #(
  parameter int FIFO_DEPTH = 4,
  parameter int DESC_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [2:0]        S_addr,
  input  logic [7:0]        S_din,
  output logic [7:0]        reg0_out,
  output logic [7:0]        reg1_out,
  output logic [7:0]        reg2_out,
  output logic [7:0]        reg3_out,
  output logic [7:0]        reg4_out,
  output logic [7:0]        reg5_out,
  output logic [7:0]        reg6_out,
  output logic [7:0]        reg7_out,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [DESC_W-1:0] desc_data,
  input  logic              op_done,
  output logic              irq
);
  import dmac_pkg::*;

  state_t            state;
  logic              intr_en;
  logic              intr;
  logic              ovf;
  logic [7:0]        src;
  logic [7:0]        dest;
  logic [7:0]        size;

  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;
  logic [DESC_W-1:0] q_dout;

  logic              wr_en;
  logic              push_req;
  logic              fifo_push;
  logic              fifo_pop;
  logic              start_ok;
  logic              intr_set;
  logic              ovf_set;

  assign wr_en     = S_sel & S_wr;
  assign push_req  = wr_en & (S_addr == ADDR_PUSH) & S_din[0];
  // Pushes are only honoured while idle, so the head never moves under an offer.
  assign fifo_push = push_req & (state == ST_IDLE) & ~q_full;
  assign ovf_set   = push_req & (state == ST_IDLE) & q_full;
  assign start_ok  = wr_en & (S_addr == ADDR_START) & S_din[0]
                     & (state == ST_IDLE) & ~q_empty;
  assign fifo_pop  = (state == ST_ISSUE) & desc_ready;
  assign intr_set  = (state == ST_WAIT) & op_done & q_empty;

  dmac_desc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({src, dest, size}),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      intr_en <= 1'b0;
      intr    <= 1'b0;
      ovf     <= 1'b0;
      src     <= 8'h00;
      dest    <= 8'h00;
      size    <= 8'h00;
    end else begin
      if (wr_en) begin
        case (S_addr)
          ADDR_INTR_EN: intr_en <= S_din[0];
          ADDR_SRC:     src     <= S_din;
          ADDR_DEST:    dest    <= S_din;
          ADDR_SIZE:    size    <= S_din;
          default:      ;
        endcase
      end

      // Hardware set beats a coincident software clear for both sticky bits.
      if (intr_set) begin
        intr <= 1'b1;
      end else if (wr_en && (S_addr == ADDR_INTR) && !S_din[0]) begin
        intr <= 1'b0;
      end

      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (wr_en && (S_addr == ADDR_STATUS) && S_din[1]) begin
        ovf <= 1'b0;
      end

      case (state)
        ST_IDLE:  if (start_ok) state <= ST_ISSUE;
        ST_ISSUE: if (desc_ready) state <= ST_WAIT;
        // Count already reflects the pop done when entering WAIT.
        ST_WAIT:  if (op_done) state <= q_empty ? ST_IDLE : ST_ISSUE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign desc_valid = (state == ST_ISSUE);
  assign desc_data  = q_dout;
  assign irq        = intr & intr_en;

  assign reg0_out = {7'b0, intr_en};
  assign reg1_out = {7'b0, intr};
  assign reg2_out = src;
  assign reg3_out = dest;
  assign reg4_out = size;
  assign reg5_out = 8'h00;
  assign reg6_out = {3'b000, q_count, ovf, (state != ST_IDLE)};
  assign reg7_out = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_dmac_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmac_slave_regs
// Description : Directed self-checking bench for dmac_slave_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmac_slave_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        S_sel, S_wr;
  logic [2:0]  S_addr;
  logic [7:0]  S_din;
  logic [7:0]  reg0_out, reg1_out, reg2_out, reg3_out;
  logic [7:0]  reg4_out, reg5_out, reg6_out, reg7_out;
  logic        desc_valid, desc_ready, op_done, irq;
  logic [23:0] desc_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmac_slave_regs #(.FIFO_DEPTH(4), .DESC_W(24)) dut (
    .clk(clk), .reset(reset),
    .S_sel(S_sel), .S_wr(S_wr), .S_addr(S_addr), .S_din(S_din),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
    .reg3_out(reg3_out), .reg4_out(reg4_out), .reg5_out(reg5_out),
    .reg6_out(reg6_out), .reg7_out(reg7_out),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .op_done(op_done), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    S_sel = 1'b1; S_wr = 1'b1; S_addr = a; S_din = d;
    tick();
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic push_desc(input logic [7:0] s, input logic [7:0] d, input logic [7:0] z);
    wr(3'd2, s); wr(3'd3, d); wr(3'd4, z); wr(3'd5, 8'h01);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!desc_valid && k < 20) begin
      tick();
      k++;
    end
    chk("wait_valid", {31'b0, desc_valid}, 32'h1);
  endtask

  task automatic handshake();
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
  endtask

  task automatic pulse_done();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  // Queue three descriptors base+j and run them; INTR must rise only at the end.
  task automatic run3(input logic [7:0] base);
    logic [7:0] s, d, z;
    for (int j = 0; j < 3; j++) begin
      s = base + 8'(j); d = base + 8'h10 + 8'(j); z = base + 8'h20 + 8'(j);
      push_desc(s, d, z);
    end
    chk("run3_count", {24'b0, reg6_out}, 32'h0C);
    wr(3'd7, 8'h01);
    for (int j = 0; j < 3; j++) begin
      s = base + 8'(j); d = base + 8'h10 + 8'(j); z = base + 8'h20 + 8'(j);
      wait_valid();
      chk("run3_data", {8'b0, desc_data}, {8'b0, s, d, z});
      handshake();
      chk("run3_busy", {31'b0, reg6_out[0]}, 32'h1);
      if (j == 0) wr(3'd2, 8'hEE);  // SRC rewrite must not disturb the queue
      chk("run3_intr_pre", {24'b0, reg1_out}, 32'h0);
      pulse_done();
    end
    chk("run3_intr", {24'b0, reg1_out}, 32'h1);
    chk("run3_status", {24'b0, reg6_out}, 32'h0);
    wr(3'd1, 8'h00);
  endtask

  initial begin
    logic [7:0] s, d, z;
    reset = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_addr = 3'd0; S_din = 8'h00;
    desc_ready = 1'b0; op_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_regs_lo", {reg3_out, reg2_out, reg1_out, reg0_out}, 32'h0);
    chk("rst_regs_hi", {reg7_out, reg6_out, reg5_out, reg4_out}, 32'h0);
    chk("rst_valid", {31'b0, desc_valid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Single transfer
    push_desc(8'h10, 8'h20, 8'h05);
    chk("single_src", {24'b0, reg2_out}, 32'h10);
    chk("single_status_q", {24'b0, reg6_out}, 32'h04);
    chk("push_reads0", {24'b0, reg5_out}, 32'h0);
    wr(3'd0, 8'h01);
    chk("intr_en", {24'b0, reg0_out}, 32'h01);
    wr(3'd7, 8'h01);
    chk("single_valid", {31'b0, desc_valid}, 32'h1);
    chk("single_data", {8'b0, desc_data}, 32'h102005);
    chk("single_busy", {24'b0, reg6_out}, 32'h05);
    tick(); tick();
    chk("single_hold_v", {31'b0, desc_valid}, 32'h1);
    chk("single_hold_d", {8'b0, desc_data}, 32'h102005);
    handshake();
    chk("single_wait_v", {31'b0, desc_valid}, 32'h0);
    chk("single_wait_st", {24'b0, reg6_out}, 32'h01);
    pulse_done();
    chk("single_irq", {31'b0, irq}, 32'h1);
    chk("single_done_st", {24'b0, reg6_out}, 32'h00);
    wr(3'd1, 8'h01);
    chk("intr_w1_noeff", {31'b0, irq}, 32'h1);
    wr(3'd1, 8'h00);
    chk("intr_clear", {31'b0, irq}, 32'h0);

    // START on empty queue
    wr(3'd7, 8'h01);
    chk("start_empty_v", {31'b0, desc_valid}, 32'h0);
    chk("start_empty_st", {24'b0, reg6_out}, 32'h00);

    // Fill and overflow, then drain in order
    for (int i = 0; i < 5; i++) push_desc(8'h30 + 8'(i), 8'h40 + 8'(i), 8'h50 + 8'(i));
    chk("ovf_status", {24'b0, reg6_out}, 32'h12);
    wr(3'd6, 8'h02);
    chk("ovf_clear", {24'b0, reg6_out}, 32'h10);
    wr(3'd7, 8'h01);
    for (int i = 0; i < 4; i++) begin
      s = 8'h30 + 8'(i); d = 8'h40 + 8'(i); z = 8'h50 + 8'(i);
      wait_valid();
      chk("drain_data", {8'b0, desc_data}, {8'b0, s, d, z});
      handshake();
      pulse_done();
    end
    chk("drain_irq", {31'b0, irq}, 32'h1);
    wr(3'd1, 8'h00);

    // Multi-descriptor runs; pointers wrap across them
    run3(8'h60);
    run3(8'h80);
    run3(8'hA0);

    // INTR clear coinciding with final op_done: set wins
    push_desc(8'hA1, 8'hB2, 8'hC3);
    wr(3'd7, 8'h01);
    wait_valid();
    chk("race_data", {8'b0, desc_data}, 32'hA1B2C3);
    handshake();
    S_sel = 1'b1; S_wr = 1'b1; S_addr = 3'd1; S_din = 8'h00; op_done = 1'b1;
    tick();
    S_sel = 1'b0; S_wr = 1'b0; op_done = 1'b0;
    chk("race_intr", {24'b0, reg1_out}, 32'h01);
    chk("race_irq", {31'b0, irq}, 32'h1);
    wr(3'd1, 8'h00);

    // Reset while in WAIT with one descriptor still queued
    push_desc(8'h11, 8'h22, 8'h33);
    push_desc(8'h44, 8'h55, 8'h66);
    wr(3'd7, 8'h01);
    wait_valid();
    handshake();
    chk("pre_rst_st", {24'b0, reg6_out}, 32'h05);
    reset = 1'b1;
    tick();
    chk("midrst_valid", {31'b0, desc_valid}, 32'h0);
    chk("midrst_st", {24'b0, reg6_out}, 32'h00);
    chk("midrst_regs", {reg3_out, reg2_out, reg1_out, reg0_out}, 32'h0);
    chk("midrst_data", {8'b0, desc_data}, 32'h0);
    reset = 1'b0;
    pulse_done();
    chk("post_rst_st", {24'b0, reg6_out}, 32'h00);
    chk("post_rst_intr", {24'b0, reg1_out}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
